// File: rtl/ctrl_seq.sv
// Multi-cycle instruction sequencer: Moore FSM driving the datapath strobes and
// register enables, with a saturating memory-wait counter and optional timeout.
module ctrl_seq #(
   parameter int OP_W     = 3,
   parameter int WAIT_MAX = 8,
   parameter int CNT_W    = 4
) (
   input  logic            clk,
   input  logic            clr,
   input  logic [OP_W-1:0] op,
   input  logic            zero,
   input  logic            mem_rdy,
   output logic [1:0]      mux_sum,
   output logic            mux_y,
   output logic            we,
   output logic            r,
   output logic            en_fetch,
   output logic [5:0]      inst_en,
   output logic            halted,
   output logic            err,
   output logic [3:0]      state_o
);

   typedef enum logic [3:0] {
      S_INIT0  = 4'd0,
      S_INIT1  = 4'd1,
      S_INIT2  = 4'd2,
      S_INIT3  = 4'd3,
      S_FETCH  = 4'd4,
      S_LATCH  = 4'd5,
      S_DECODE = 4'd6,
      S_MEMRD  = 4'd7,
      S_MEMWR  = 4'd8,
      S_WB     = 4'd9,
      S_ALU    = 4'd10,
      S_JUMP   = 4'd11,
      S_HALT   = 4'd12,
      S_ERR    = 4'd13,
      S_BAD14  = 4'd14,
      S_BAD15  = 4'd15
   } state_t;

   localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);
   localparam logic [CNT_W-1:0] CNT_SAT  = '1;

   state_t           state_q, next_state;
   logic             run_q;
   logic [CNT_W-1:0] wait_cnt;
   logic [2:0]       op_q;
   logic             timeout;
   logic             in_wait;

   // One flop after clr release so the first advance lands on the second edge.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) run_q <= 1'b0;
      else      run_q <= 1'b1;
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q  <= S_INIT0;
         wait_cnt <= '0;
         op_q     <= '0;
      end else if (run_q) begin
         state_q <= next_state;
         if (state_q == S_DECODE) op_q <= op[2:0];
         // Cleared outside wait states and on the completing cycle, so every entry starts at 0.
         if (!in_wait || mem_rdy)   wait_cnt <= '0;
         else if (wait_cnt != CNT_SAT) wait_cnt <= wait_cnt + 1'b1;
      end
   end

   assign in_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
   assign timeout = (WAIT_MAX != 0) && (wait_cnt >= WAIT_LIM) && !mem_rdy;

   always_comb begin
      next_state = state_q;
      case (state_q)
         S_INIT0:  next_state = S_INIT1;
         S_INIT1:  next_state = S_INIT2;
         S_INIT2:  next_state = S_INIT3;
         S_INIT3:  next_state = S_FETCH;
         S_FETCH: begin
            if (mem_rdy)      next_state = S_LATCH;
            else if (timeout) next_state = S_ERR;
         end
         S_LATCH:  next_state = S_DECODE;
         S_DECODE: begin
            if ((op >> 3) != '0) next_state = S_ERR;
            else begin
               case (op[2:0])
                  3'b000:  next_state = S_MEMRD;
                  3'b001:  next_state = S_MEMWR;
                  3'b010:  next_state = S_ALU;
                  3'b011:  next_state = S_ALU;
                  3'b100:  next_state = S_JUMP;
                  3'b101:  next_state = zero ? S_JUMP : S_FETCH;
                  3'b110:  next_state = S_FETCH;
                  default: next_state = S_HALT;
               endcase
            end
         end
         S_MEMRD: begin
            if (mem_rdy)      next_state = S_WB;
            else if (timeout) next_state = S_ERR;
         end
         S_MEMWR: begin
            if (mem_rdy)      next_state = S_FETCH;
            else if (timeout) next_state = S_ERR;
         end
         S_WB:     next_state = S_FETCH;
         S_ALU:    next_state = S_FETCH;
         S_JUMP:   next_state = S_FETCH;
         S_HALT:   next_state = S_HALT;
         S_ERR:    next_state = S_ERR;
         default:  next_state = S_ERR;
      endcase
   end

   always_comb begin
      mux_sum  = 2'b00;
      mux_y    = 1'b0;
      we       = 1'b0;
      r        = 1'b0;
      en_fetch = 1'b0;
      inst_en  = 6'b000000;
      halted   = 1'b0;
      err      = 1'b0;
      case (state_q)
         S_INIT1:  inst_en = 6'b100000;
         S_INIT2:  inst_en = 6'b110000;
         S_INIT3:  inst_en = 6'b111111;
         S_FETCH: begin
            r        = 1'b1;
            en_fetch = 1'b1;
         end
         S_LATCH:  inst_en = 6'b110000;
         S_DECODE: inst_en = 6'b001010;
         S_MEMRD:  r = 1'b1;
         S_MEMWR:  we = 1'b1;
         S_WB: begin
            inst_en = 6'b000001;
            mux_y   = 1'b1;
         end
         S_ALU: begin
            inst_en = 6'b000100;
            mux_sum = (op_q == 3'b011) ? 2'b10 : 2'b01;
         end
         S_JUMP: begin
            inst_en = 6'b100000;
            mux_sum = 2'b11;
         end
         S_HALT:   halted = 1'b1;
         S_ERR:    err = 1'b1;
         default: ;
      endcase
   end

   assign state_o = state_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: reset/timeout/halt sequences, a latency table, and a random
// instruction stream checked cycle by cycle against an instruction-level model.
module tb_ctrl_seq;

   localparam int ST_INIT0 = 0, ST_INIT1 = 1, ST_INIT2 = 2, ST_INIT3 = 3, ST_FETCH = 4;
   localparam int ST_LATCH = 5, ST_DECODE = 6, ST_MEMRD = 7, ST_MEMWR = 8, ST_WB = 9;
   localparam int ST_ALU = 10, ST_JUMP = 11, ST_HALT = 12, ST_ERR = 13;

   logic       clk, clr;
   logic [2:0] op;
   logic       zero, mem_rdy;
   logic [1:0] mux_sum;
   logic       mux_y, we, r, en_fetch, halted, err;
   logic [5:0] inst_en;
   logic [3:0] state_o;

   logic [3:0] op2;
   logic       zero2, mem_rdy2;
   logic [1:0] mux_sum2;
   logic       mux_y2, we2, r2, en_fetch2, halted2, err2;
   logic [5:0] inst_en2;
   logic [3:0] state_o2;

   logic [17:0] outs;
   assign outs = {state_o, mux_sum, mux_y, we, r, en_fetch, inst_en, halted, err};

   int n_pass = 0;
   int n_total = 0;

   logic [17:0] exp_q[$];
   logic [4:0]  stim_q[$];

   ctrl_seq #(.OP_W(3), .WAIT_MAX(8), .CNT_W(4)) dut (
      .clk(clk), .clr(clr), .op(op), .zero(zero), .mem_rdy(mem_rdy),
      .mux_sum(mux_sum), .mux_y(mux_y), .we(we), .r(r), .en_fetch(en_fetch),
      .inst_en(inst_en), .halted(halted), .err(err), .state_o(state_o)
   );

   ctrl_seq #(.OP_W(4), .WAIT_MAX(0), .CNT_W(4)) dut2 (
      .clk(clk), .clr(clr), .op(op2), .zero(zero2), .mem_rdy(mem_rdy2),
      .mux_sum(mux_sum2), .mux_y(mux_y2), .we(we2), .r(r2), .en_fetch(en_fetch2),
      .inst_en(inst_en2), .halted(halted2), .err(err2), .state_o(state_o2)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Expected output vector for a state, from the per-state output table.
   function automatic logic [17:0] exp_out(input int st, input logic sub);
      logic [1:0] ms;
      logic       my, w, rd, ef, h, e;
      logic [5:0] ie;
      ms = 2'b00; my = 0; w = 0; rd = 0; ef = 0; h = 0; e = 0; ie = 6'b0;
      case (st)
         ST_INIT1:  ie = 6'b100000;
         ST_INIT2:  ie = 6'b110000;
         ST_INIT3:  ie = 6'b111111;
         ST_FETCH:  begin rd = 1; ef = 1; end
         ST_LATCH:  ie = 6'b110000;
         ST_DECODE: ie = 6'b001010;
         ST_MEMRD:  rd = 1;
         ST_MEMWR:  w = 1;
         ST_WB:     begin ie = 6'b000001; my = 1; end
         ST_ALU:    begin ie = 6'b000100; ms = sub ? 2'b10 : 2'b01; end
         ST_JUMP:   begin ie = 6'b100000; ms = 2'b11; end
         ST_HALT:   h = 1;
         ST_ERR:    e = 1;
         default: ;
      endcase
      return {4'(st), ms, my, w, rd, ef, ie, h, e};
   endfunction

   // scoreboard compare
   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, want, $time);
   endtask

   // driver: check this cycle's outputs, then drive this cycle's inputs
   task automatic step(input string nm, input logic [17:0] want, input logic mr,
                       input logic [2:0] o, input logic z);
      @(negedge clk);
      check(nm, {14'b0, outs}, {14'b0, want});
      mem_rdy = mr;
      op      = o;
      zero    = z;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clr = 1'b0;
      #1;
      check("reset_async", {14'b0, outs}, 32'h0);
      check("reset_async2", {28'b0, state_o2}, 32'h0);
      repeat (2) @(negedge clk);
      clr = 1'b1;
      step("rst_init0", exp_out(ST_INIT0, 0), 0, 0, 0);
      step("rst_init1", exp_out(ST_INIT1, 0), 0, 0, 0);
      step("rst_init2", exp_out(ST_INIT2, 0), 0, 0, 0);
      step("rst_init3", exp_out(ST_INIT3, 0), 0, 0, 0);
   endtask

   task automatic push(input int st, input logic sub, input logic mr, input logic [2:0] o,
                       input logic z);
      exp_q.push_back(exp_out(st, sub));
      stim_q.push_back({mr, z, o});
   endtask

   // Instruction-level model: expand one instruction into its cycle-by-cycle trace.
   task automatic gen_inst(input logic [2:0] o, input logic z, input int wf, input int wm);
      for (int i = 0; i < wf; i++) push(ST_FETCH, 0, 0, 3'($urandom), 1'($urandom));
      push(ST_FETCH, 0, 1, 3'($urandom), 1'($urandom));
      push(ST_LATCH, 0, 1'($urandom), 3'($urandom), 1'($urandom));
      push(ST_DECODE, 0, 1'($urandom), o, z);
      case (o)
         3'd0: begin
            for (int i = 0; i < wm; i++) push(ST_MEMRD, 0, 0, 3'($urandom), 1'($urandom));
            push(ST_MEMRD, 0, 1, 3'($urandom), 1'($urandom));
            push(ST_WB, 0, 1'($urandom), 3'($urandom), 1'($urandom));
         end
         3'd1: begin
            for (int i = 0; i < wm; i++) push(ST_MEMWR, 0, 0, 3'($urandom), 1'($urandom));
            push(ST_MEMWR, 0, 1, 3'($urandom), 1'($urandom));
         end
         3'd2, 3'd3: push(ST_ALU, o[0], 1'($urandom), 3'($urandom), 1'($urandom));
         3'd4: push(ST_JUMP, 0, 1'($urandom), 3'($urandom), 1'($urandom));
         3'd5: if (z) push(ST_JUMP, 0, 1'($urandom), 3'($urandom), 1'($urandom));
         3'd7: for (int i = 0; i < 20; i++)
                  push(ST_HALT, 0, 1'($urandom), 3'($urandom), 1'($urandom));
         default: ;
      endcase
   endtask

   typedef struct {
      logic [2:0] op;
      logic       z;
      int         wm;
      int         lat;
      int         post;
   } vec_t;

   vec_t vecs[11];

   // Run one instruction starting in FETCH; measure cycles back to FETCH.
   task automatic run_vec(input vec_t v, output int lat, output int post);
      int wcnt;
      wcnt = 0;
      lat  = 0;
      post = -1;
      op = v.op; zero = v.z; mem_rdy = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (n == 3) post = int'(state_o);
         if (int'(state_o) == ST_FETCH) begin
            lat = n;
            break;
         end
         if (int'(state_o) == ST_MEMRD || int'(state_o) == ST_MEMWR) begin
            mem_rdy = (wcnt >= v.wm);
            wcnt++;
         end else begin
            mem_rdy = 1'b1;
         end
      end
   endtask

   initial begin
      int lat, post, ninst;
      logic [2:0] o;
      vecs[0]  = '{3'd6, 1'b0, 0, 3,  ST_FETCH};
      vecs[1]  = '{3'd2, 1'b0, 0, 4,  ST_ALU};
      vecs[2]  = '{3'd3, 1'b1, 0, 4,  ST_ALU};
      vecs[3]  = '{3'd4, 1'b0, 0, 4,  ST_JUMP};
      vecs[4]  = '{3'd5, 1'b0, 0, 3,  ST_FETCH};
      vecs[5]  = '{3'd5, 1'b1, 0, 4,  ST_JUMP};
      vecs[6]  = '{3'd1, 1'b0, 0, 4,  ST_MEMWR};
      vecs[7]  = '{3'd0, 1'b0, 0, 5,  ST_MEMRD};
      vecs[8]  = '{3'd0, 1'b0, 3, 8,  ST_MEMRD};
      vecs[9]  = '{3'd1, 1'b0, 2, 6,  ST_MEMWR};
      vecs[10] = '{3'd0, 1'b1, 8, 13, ST_MEMRD};

      clr = 1'b0; op = '0; zero = 0; mem_rdy = 0;
      op2 = '0; zero2 = 0; mem_rdy2 = 0;

      // reset release and fetch-wait timeout
      do_reset();
      step("fetch_first", exp_out(ST_FETCH, 0), 0, 0, 0);
      for (int i = 1; i <= 8; i++) step("fetch_wait", exp_out(ST_FETCH, 0), 0, 0, 0);
      step("timeout_err", exp_out(ST_ERR, 0), 1, 3'd2, 0);
      for (int i = 0; i < 3; i++) step("err_terminal", exp_out(ST_ERR, 0), 1, 3'd6, 0);

      // latency table
      do_reset();
      step("tbl_fetch", exp_out(ST_FETCH, 0), 0, 0, 0);
      for (int i = 0; i < 11; i++) begin
         run_vec(vecs[i], lat, post);
         check($sformatf("tbl_lat[%0d]", i), lat, vecs[i].lat);
         check($sformatf("tbl_post[%0d]", i), post, vecs[i].post);
      end

      // random instruction stream ending in HALT
      do_reset();
      ninst = 40;
      for (int k = 0; k < ninst; k++) begin
         o = 3'($urandom_range(0, 6));
         gen_inst(o, 1'($urandom), $urandom_range(0, 8), $urandom_range(0, 8));
      end
      gen_inst(3'd7, 1'b0, $urandom_range(0, 3), 0);
      while (exp_q.size() > 0) begin
         logic [17:0] e;
         logic [4:0]  s;
         e = exp_q.pop_front();
         s = stim_q.pop_front();
         step("rand", e, s[4], s[2:0], s[3]);
      end

      // wide opcode with timeout disabled
      do_reset();
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         check("nto_fetch_hold", {28'b0, state_o2}, ST_FETCH);
         mem_rdy2 = 1'b0;
      end
      mem_rdy2 = 1'b1;
      @(negedge clk);
      check("nto_latch", {28'b0, state_o2}, ST_LATCH);
      @(negedge clk);
      check("nto_decode", {28'b0, state_o2}, ST_DECODE);
      op2 = 4'b1000;
      @(negedge clk);
      check("wide_op_err", {28'b0, state_o2, err2}, {ST_ERR, 1'b1});
      check("wide_op_quiet", {22'b0, r2, we2, en_fetch2, inst_en2, halted2},
            32'h0);
      do_reset();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ctrl_seq.md
CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 Parameter OP_W, 3, opcode width; SHALL be >= 3.
REQ-002 Parameter WAIT_MAX, 8, max mem_rdy wait cycles before timeout; 0 disables timeout.
REQ-003 Parameter CNT_W, 4, wait-counter width; SHALL satisfy 2^CNT_W > WAIT_MAX.
REQ-004 Port clk  in  1  single clock; all state changes on rising edge.
REQ-005 Port clr  in  1  reset, asynchronous, active-low.
REQ-006 Port op  in  OP_W  opcode from instruction register.
REQ-007 Port zero  in  1  datapath zero flag.
REQ-008 Port mem_rdy  in  1  memory transfer complete.
REQ-009 Port mux_sum  out  2  adder/PC source select.
REQ-010 Port mux_y  out  1  Y/X writeback source select.
REQ-011 Port we  out  1  memory write strobe.
REQ-012 Port r  out  1  memory read strobe.
REQ-013 Port en_fetch  out  1  fetch address path enable.
REQ-014 Port inst_en  out  6  register enables {PC_EN, INST_EN, ADDR_EN, Y_EN, OP_EN, X_EN}, bit 5 first.
REQ-015 Port halted, err  out  1 each  status flags.
REQ-016 Port state_o  out  4  current state encoding.

Function
REQ-017 States/encoding: INIT0=0, INIT1=1, INIT2=2, INIT3=3, FETCH=4, LATCH=5, DECODE=6, MEMRD=7, MEMWR=8, WB=9, ALU=10, JUMP=11, HALT=12, ERR=13; codes 14-15 SHALL go to ERR.
REQ-018 All outputs SHALL be Moore decodes of the state register; unlisted outputs 0 in every state.
REQ-019 INIT0->INIT1->INIT2->INIT3->FETCH, one cycle each, unconditional; inst_en 000000, 100000, 110000, 111111 respectively.
REQ-020 FETCH: r=1, en_fetch=1; mem_rdy=1 -> LATCH, else hold.
REQ-021 LATCH: inst_en=110000 (IR load, PC increment), one cycle -> DECODE.
REQ-022 DECODE: inst_en=001010; next state from op and zero sampled this cycle.
REQ-023 Decode: op[OP_W-1:3] nonzero -> ERR; else op[2:0]: 000 LOAD->MEMRD; 001 STORE->MEMWR; 010 ADD->ALU; 011 SUB->ALU; 100 JMP->JUMP; 101 JZ->JUMP if zero=1 else FETCH; 110 NOP->FETCH; 111 HALT->HALT.
REQ-024 Opcode SHALL be latched into an internal register in DECODE; ALU outputs use the latched value.
REQ-025 MEMRD: r=1, mux_sum=00; mem_rdy=1 -> WB, else hold.
REQ-026 WB: inst_en=000001, mux_y=1, one cycle -> FETCH.
REQ-027 MEMWR: we=1; mem_rdy=1 -> FETCH, else hold.
REQ-028 ALU: inst_en=000100, mux_y=0, mux_sum=01 (ADD) or 10 (SUB), one cycle -> FETCH.
REQ-029 JUMP: inst_en=100000, mux_sum=11, one cycle -> FETCH.
REQ-030 HALT: halted=1, inst_en=000000; terminal until reset.
REQ-031 ERR: err=1, all strobes/enables 0; terminal until reset.
REQ-032 Wait counter SHALL clear on entry to FETCH, MEMRD, MEMWR and increment each cycle there with mem_rdy=0.
REQ-033 WAIT_MAX>0: counter reaching WAIT_MAX with mem_rdy still 0 -> ERR next edge; mem_rdy=1 on that same cycle SHALL win (normal transition).
REQ-034 WAIT_MAX=0: no timeout; wait states hold indefinitely.
REQ-035 Counter SHALL saturate, never wrap.
REQ-036 Per-instruction latency from FETCH entry with mem_rdy=1 immediately: NOP 3, ADD/SUB/JMP 4, STORE 4, LOAD 5 cycles.

Reset
REQ-037 clr=0 SHALL force state INIT0, wait counter 0, latched opcode 0, all outputs 0, asynchronously, from any state including mid-wait, HALT and ERR.
REQ-038 Release of clr SHALL be synchronised so first transition (INIT0->INIT1) occurs on the second rising edge after deassertion.

Verification
REQ-039 Reset release -> state_o 0,1,2,3,4 on successive cycles; inst_en 000000,100000,110000,111111, then FETCH with r=1, en_fetch=1.
REQ-040 mem_rdy=1, op=010 -> FETCH,LATCH,DECODE,ALU(mux_sum=01, inst_en=000100),FETCH.
REQ-041 op=101, zero=0 -> DECODE->FETCH; zero=1 -> JUMP with mux_sum=11, inst_en=100000.
REQ-042 op=000, mem_rdy low 3 cycles in MEMRD -> r=1 held 4 cycles, then WB (inst_en=000001, mux_y=1).
REQ-043 WAIT_MAX=8, mem_rdy=0 in FETCH -> ERR after 9 cycles, err=1; reassert clr=0 -> all outputs 0 immediately.
REQ-044 op=111 -> HALT, halted=1 stable for 20 cycles regardless of mem_rdy/op; OP_W=4, op=1000 -> ERR.
